// File: rtl/ysyx_25040109_axi_pkg.sv
// Shared types and constants for the IFU/LSU AXI4 arbiter.
package ysyx_25040109_axi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_IFU,
        RD_LSU,
        WR_LSU
    } axi_state_e;

    typedef enum logic {
        GNT_IFU,
        GNT_LSU
    } grant_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

endpackage

// File: rtl/ysyx_25040109_axi_arbiter.sv
// 2-to-1 AXI4 arbiter: IFU (read) and LSU (read/write) share one memory port,
// one burst at a time, held until its final response handshake.
module ysyx_25040109_axi_arbiter
    import ysyx_25040109_axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned FAIR   = 1
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ifu_arvalid,
    output logic                  ifu_arready,
    input  logic [ADDR_W-1:0]     ifu_araddr,
    input  logic [ID_W-1:0]       ifu_arid,
    input  logic [LEN_W-1:0]      ifu_arlen,
    input  logic [SIZE_W-1:0]     ifu_arsize,
    input  logic [BURST_W-1:0]    ifu_arburst,
    output logic                  ifu_rvalid,
    input  logic                  ifu_rready,
    output logic [DATA_W-1:0]     ifu_rdata,
    output logic [RESP_W-1:0]     ifu_rresp,
    output logic [ID_W-1:0]       ifu_rid,
    output logic                  ifu_rlast,

    input  logic                  lsu_arvalid,
    output logic                  lsu_arready,
    input  logic [ADDR_W-1:0]     lsu_araddr,
    input  logic [ID_W-1:0]       lsu_arid,
    input  logic [LEN_W-1:0]      lsu_arlen,
    input  logic [SIZE_W-1:0]     lsu_arsize,
    input  logic [BURST_W-1:0]    lsu_arburst,
    output logic                  lsu_rvalid,
    input  logic                  lsu_rready,
    output logic [DATA_W-1:0]     lsu_rdata,
    output logic [RESP_W-1:0]     lsu_rresp,
    output logic [ID_W-1:0]       lsu_rid,
    output logic                  lsu_rlast,
    input  logic                  lsu_awvalid,
    output logic                  lsu_awready,
    input  logic [ADDR_W-1:0]     lsu_awaddr,
    input  logic [ID_W-1:0]       lsu_awid,
    input  logic [LEN_W-1:0]      lsu_awlen,
    input  logic [SIZE_W-1:0]     lsu_awsize,
    input  logic [BURST_W-1:0]    lsu_awburst,
    input  logic                  lsu_wvalid,
    output logic                  lsu_wready,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wstrb,
    input  logic                  lsu_wlast,
    output logic                  lsu_bvalid,
    input  logic                  lsu_bready,
    output logic [RESP_W-1:0]     lsu_bresp,
    output logic [ID_W-1:0]       lsu_bid,

    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [ADDR_W-1:0]     mem_araddr,
    output logic [ID_W-1:0]       mem_arid,
    output logic [LEN_W-1:0]      mem_arlen,
    output logic [SIZE_W-1:0]     mem_arsize,
    output logic [BURST_W-1:0]    mem_arburst,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic [RESP_W-1:0]     mem_rresp,
    input  logic [ID_W-1:0]       mem_rid,
    input  logic                  mem_rlast,
    output logic                  mem_awvalid,
    input  logic                  mem_awready,
    output logic [ADDR_W-1:0]     mem_awaddr,
    output logic [ID_W-1:0]       mem_awid,
    output logic [LEN_W-1:0]      mem_awlen,
    output logic [SIZE_W-1:0]     mem_awsize,
    output logic [BURST_W-1:0]    mem_awburst,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_wlast,
    input  logic                  mem_bvalid,
    output logic                  mem_bready,
    input  logic [RESP_W-1:0]     mem_bresp,
    input  logic [ID_W-1:0]       mem_bid
);

    axi_state_e state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_LSU;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_awvalid) begin
                    state_d = WR_LSU;
                end else if (lsu_arvalid && ifu_arvalid) begin
                    state_d = (FAIR != 0 && last_grant_q == GNT_LSU) ? RD_IFU : RD_LSU;
                end else if (ifu_arvalid) begin
                    state_d = RD_IFU;
                end else if (lsu_arvalid) begin
                    state_d = RD_LSU;
                end
            end
            RD_IFU, RD_LSU: begin
                if (mem_arvalid && mem_arready) ar_done_d = 1'b1;
                // rlast alone ends the burst; there is no beat counter
                if (mem_rvalid && mem_rready && mem_rlast) begin
                    state_d      = IDLE;
                    ar_done_d    = 1'b0;
                    last_grant_d = (state_q == RD_IFU) ? GNT_IFU : GNT_LSU;
                end
            end
            WR_LSU: begin
                if (mem_awvalid && mem_awready) aw_done_d = 1'b1;
                if (mem_bvalid && mem_bready) begin
                    state_d      = IDLE;
                    aw_done_d    = 1'b0;
                    last_grant_d = GNT_LSU;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifu_arready = '0; ifu_rvalid = '0; ifu_rdata = '0;
        ifu_rresp   = '0; ifu_rid    = '0; ifu_rlast = '0;
        lsu_arready = '0; lsu_rvalid = '0; lsu_rdata = '0;
        lsu_rresp   = '0; lsu_rid    = '0; lsu_rlast = '0;
        lsu_awready = '0; lsu_wready = '0;
        lsu_bvalid  = '0; lsu_bresp  = '0; lsu_bid   = '0;
        mem_arvalid = '0; mem_araddr = '0; mem_arid  = '0;
        mem_arlen   = '0; mem_arsize = '0; mem_arburst = '0;
        mem_rready  = '0;
        mem_awvalid = '0; mem_awaddr = '0; mem_awid  = '0;
        mem_awlen   = '0; mem_awsize = '0; mem_awburst = '0;
        mem_wvalid  = '0; mem_wdata  = '0; mem_wstrb = '0; mem_wlast = '0;
        mem_bready  = '0;
        unique case (state_q)
            RD_IFU: begin
                mem_arvalid = ifu_arvalid & ~ar_done_q;
                ifu_arready = mem_arready & ~ar_done_q;
                mem_araddr  = ifu_araddr;
                mem_arid    = ifu_arid;
                mem_arlen   = ifu_arlen;
                mem_arsize  = ifu_arsize;
                mem_arburst = ifu_arburst;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rid     = mem_rid;
                ifu_rlast   = mem_rlast;
            end
            RD_LSU: begin
                mem_arvalid = lsu_arvalid & ~ar_done_q;
                lsu_arready = mem_arready & ~ar_done_q;
                mem_araddr  = lsu_araddr;
                mem_arid    = lsu_arid;
                mem_arlen   = lsu_arlen;
                mem_arsize  = lsu_arsize;
                mem_arburst = lsu_arburst;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rid     = mem_rid;
                lsu_rlast   = mem_rlast;
            end
            WR_LSU: begin
                // W may run ahead of AW; only AW is gated after its handshake
                mem_awvalid = lsu_awvalid & ~aw_done_q;
                lsu_awready = mem_awready & ~aw_done_q;
                mem_awaddr  = lsu_awaddr;
                mem_awid    = lsu_awid;
                mem_awlen   = lsu_awlen;
                mem_awsize  = lsu_awsize;
                mem_awburst = lsu_awburst;
                mem_wvalid  = lsu_wvalid;
                lsu_wready  = mem_wready;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wlast   = lsu_wlast;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
                lsu_bresp   = mem_bresp;
                lsu_bid     = mem_bid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040109_axi_arbiter.sv
// Scoreboard bench for the IFU/LSU arbiter with a behavioural memory responder.
module tb_ysyx_25040109_axi_arbiter;

    logic clock = 0, reset = 0;
    always #5 clock = ~clock;

    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [3:0]  ifu_arid, ifu_rid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready, lsu_rlast;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [3:0]  lsu_arid, lsu_rid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_wlast;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [3:0]  lsu_awid, lsu_wstrb, lsu_bid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
    logic [31:0] mem_araddr, mem_rdata;
    logic [3:0]  mem_arid, mem_rid;
    logic [7:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst, mem_rresp;
    logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_wlast;
    logic        mem_bvalid, mem_bready;
    logic [31:0] mem_awaddr, mem_wdata;
    logic [3:0]  mem_awid, mem_wstrb, mem_bid;
    logic [7:0]  mem_awlen;
    logic [2:0]  mem_awsize;
    logic [1:0]  mem_awburst, mem_bresp;

    ysyx_25040109_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .FAIR(1)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arid(ifu_arid), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rid(ifu_rid), .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arid(lsu_arid), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rid(lsu_rid), .lsu_rlast(lsu_rlast),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awid(lsu_awid), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arid(mem_arid), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp), .mem_rid(mem_rid), .mem_rlast(mem_rlast),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
        .mem_awid(mem_awid), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready), .mem_bresp(mem_bresp), .mem_bid(mem_bid)
    );

    // src: 0 = IFU R, 1 = LSU R, 2 = LSU B
    typedef struct {
        int          src;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int src, input logic [31:0] d, input logic [1:0] r,
                        input logic [3:0] id, input logic l);
        exp_t e;
        e.src = src; e.data = d; e.resp = r; e.id = id; e.last = l;
        exp_q.push_back(e);
    endtask

    // Behavioural memory: word index = addr[9:2], address 0 answers SLVERR.
    logic [31:0] mem [0:255];
    initial begin
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, s_wlast, rd_busy, wr_aw, bpend, rd_err;
        logic [31:0] s_araddr, s_awaddr, s_wdata;
        logic [3:0]  s_arid, s_awid, s_wstrb, rd_id, wr_id;
        logic [7:0]  s_arlen, rd_idx, rd_left, wr_idx;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0000_0413;
        rd_busy = 0; wr_aw = 0; bpend = 0; rd_err = 0;
        rd_idx = 0; rd_left = 0; wr_idx = 0; rd_id = 0; wr_id = 0;
        mem_arready = 0; mem_rvalid = 0; mem_rdata = 0; mem_rresp = 0; mem_rid = 0; mem_rlast = 0;
        mem_awready = 0; mem_wready = 0; mem_bvalid = 0; mem_bresp = 0; mem_bid = 0;
        forever begin
            @(negedge clock);
            ar_hs = mem_arvalid && mem_arready;  r_hs = mem_rvalid && mem_rready;
            aw_hs = mem_awvalid && mem_awready;  w_hs = mem_wvalid && mem_wready;
            b_hs  = mem_bvalid && mem_bready;
            s_araddr = mem_araddr; s_arid = mem_arid; s_arlen = mem_arlen;
            s_awaddr = mem_awaddr; s_awid = mem_awid;
            s_wdata = mem_wdata; s_wstrb = mem_wstrb; s_wlast = mem_wlast;
            @(posedge clock); #1;
            if (!reset) begin
                rd_busy = 0; wr_aw = 0; bpend = 0;
            end else begin
                if (ar_hs) begin
                    rd_busy = 1; rd_idx = s_araddr[9:2]; rd_left = s_arlen;
                    rd_id = s_arid; rd_err = (s_araddr == 32'h0);
                end else if (r_hs) begin
                    if (rd_left == 0) rd_busy = 0;
                    else begin rd_left = rd_left - 1; rd_idx = rd_idx + 1; end
                end
                if (aw_hs) begin wr_aw = 1; wr_idx = s_awaddr[9:2]; wr_id = s_awid; end
                if (w_hs) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[wr_idx][b*8 +: 8] = s_wdata[b*8 +: 8];
                    wr_idx = wr_idx + 1;
                    if (s_wlast) begin wr_aw = 0; bpend = 1; end
                end
                if (b_hs) bpend = 0;
            end
            mem_arready = !rd_busy && !wr_aw && !bpend;
            mem_rvalid  = rd_busy;
            mem_rdata   = mem[rd_idx];
            mem_rresp   = rd_err ? 2'b10 : 2'b00;
            mem_rid     = rd_id;
            mem_rlast   = rd_busy && (rd_left == 0);
            mem_awready = !wr_aw && !bpend && !rd_busy;
            mem_wready  = wr_aw;
            mem_bvalid  = bpend;
            mem_bresp   = 2'b00;
            mem_bid     = wr_id;
        end
    end

    // Monitor: every R/B handshake seen by a master pops one expected response.
    initial begin
        int src, got, nrdy;
        logic [31:0] d; logic [1:0] r; logic [3:0] id; logic l;
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                got = 0; src = 0; d = 0; r = 0; id = 0; l = 0;
                if (ifu_rvalid && ifu_rready) begin src = 0; d = ifu_rdata; r = ifu_rresp; id = ifu_rid; l = ifu_rlast; got++; end
                if (lsu_rvalid && lsu_rready) begin src = 1; d = lsu_rdata; r = lsu_rresp; id = lsu_rid; l = lsu_rlast; got++; end
                if (lsu_bvalid && lsu_bready) begin src = 2; d = 0; r = lsu_bresp; id = lsu_bid; l = 1; got++; end
                if (got > 1) begin
                    checks++; errors++;
                    $display("FAIL multi_resp: %0d responses in one cycle, required 1", got);
                end else if (got == 1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: src=%0d data=%h resp=%h id=%h, required none", src, d, r, id);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.src != src || e.data != d || e.resp != r || e.id != id || e.last != l) begin
                            errors++;
                            $display("FAIL resp: got src=%0d data=%h resp=%h id=%h last=%b, required src=%0d data=%h resp=%h id=%h last=%b",
                                     src, d, r, id, l, e.src, e.data, e.resp, e.id, e.last);
                        end
                    end
                end
                nrdy = int'(ifu_arready) + int'(lsu_arready) + int'(lsu_awready);
                if (nrdy > 0) begin
                    checks++;
                    if (nrdy > 1) begin
                        errors++;
                        $display("FAIL grant_exclusive: %0d address readies high, required 1", nrdy);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic ifu_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        bit hs = 0;
        ifu_arvalid = 1; ifu_araddr = a; ifu_arid = id; ifu_arlen = len;
        ifu_arsize = 3'd2; ifu_arburst = 2'b01;
        for (int n = 0; n < 300 && !hs; n++) begin
            @(negedge clock); hs = ifu_arready;
            tick();
        end
        ifu_arvalid = 0;
        checks++;
        if (!hs) begin errors++; $display("FAIL ifu_ar_timeout: handshake=0, required 1"); end
    endtask

    task automatic lsu_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        bit hs = 0;
        lsu_arvalid = 1; lsu_araddr = a; lsu_arid = id; lsu_arlen = len;
        lsu_arsize = 3'd2; lsu_arburst = 2'b01;
        for (int n = 0; n < 300 && !hs; n++) begin
            @(negedge clock); hs = lsu_arready;
            tick();
        end
        lsu_arvalid = 0;
        checks++;
        if (!hs) begin errors++; $display("FAIL lsu_ar_timeout: handshake=0, required 1"); end
    endtask

    task automatic lsu_wr(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d, input logic [3:0] s);
        bit aw_ok = 0, w_ok = 0, a_hs, w_hs;
        lsu_awvalid = 1; lsu_awaddr = a; lsu_awid = id; lsu_awlen = 0; lsu_awsize = 3'd2; lsu_awburst = 2'b01;
        lsu_wvalid = 1; lsu_wdata = d; lsu_wstrb = s; lsu_wlast = 1;
        for (int n = 0; n < 300 && !(aw_ok && w_ok); n++) begin
            @(negedge clock);
            a_hs = lsu_awvalid && lsu_awready;
            w_hs = lsu_wvalid && lsu_wready;
            tick();
            if (a_hs) begin aw_ok = 1; lsu_awvalid = 0; end
            if (w_hs) begin w_ok = 1; lsu_wvalid = 0; end
        end
        lsu_awvalid = 0; lsu_wvalid = 0;
        checks++;
        if (!(aw_ok && w_ok)) begin errors++; $display("FAIL lsu_wr_timeout: aw=%b w=%b, required 1 1", aw_ok, w_ok); end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick();
        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d responses outstanding, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        bit hs;
        logic [11:0] outs;
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arid = 0; ifu_arlen = 0; ifu_arsize = 0; ifu_arburst = 0;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arid = 0; lsu_arlen = 0; lsu_arsize = 0; lsu_arburst = 0;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_awid = 0; lsu_awlen = 0; lsu_awsize = 0; lsu_awburst = 0;
        lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0;
        ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
        reset = 0;
        repeat (3) tick();
        outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready};
        checks++;
        if (outs != 12'h000) begin errors++; $display("FAIL reset_outputs: got %h, required 000", outs); end
        reset = 1;
        tick();

        // Single IFU read, then a back-to-back request sees one IDLE cycle.
        push(0, 32'h0000_0413, 2'b00, 4'h1, 1);
        ifu_ar(32'h8000_0000, 4'h1, 8'd0);
        hs = 0;
        for (int n = 0; n < 50 && !hs; n++) begin
            @(negedge clock); hs = ifu_rvalid && ifu_rready;
        end
        checks++;
        if (!hs) begin errors++; $display("FAIL t1_r_timeout: handshake=0, required 1"); end
        tick();
        push(0, 32'hA000_0001, 2'b00, 4'h2, 1);
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0004; ifu_arid = 4'h2; ifu_arlen = 0;
        @(negedge clock);
        checks++;
        if (ifu_arready !== 1'b0) begin errors++; $display("FAIL idle_after_rlast: ifu_arready=%b, required 0", ifu_arready); end
        tick();
        @(negedge clock);
        checks++;
        if (ifu_arready !== 1'b1) begin errors++; $display("FAIL grant_latency: ifu_arready=%b, required 1", ifu_arready); end
        tick();
        ifu_arvalid = 0;
        drain("t1");

        // Tie after reset: IFU first, LSU next; after an IFU-only read the tie goes to LSU.
        reset = 0; repeat (2) tick(); reset = 1; tick();
        push(0, 32'hA000_0002, 2'b00, 4'h3, 1);
        push(1, 32'hA000_0003, 2'b00, 4'h4, 1);
        fork
            ifu_ar(32'h8000_0008, 4'h3, 8'd0);
            lsu_ar(32'h8000_000C, 4'h4, 8'd0);
        join
        drain("tie1");
        push(0, 32'hA000_0004, 2'b00, 4'h3, 1);
        ifu_ar(32'h8000_0010, 4'h3, 8'd0);
        drain("solo");
        push(1, 32'hA000_0006, 2'b00, 4'h4, 1);
        push(0, 32'hA000_0005, 2'b00, 4'h3, 1);
        fork
            ifu_ar(32'h8000_0014, 4'h3, 8'd0);
            lsu_ar(32'h8000_0018, 4'h4, 8'd0);
        join
        drain("tie2");

        // Write beats a simultaneous IFU read; partial-strobe result read back.
        push(2, 32'h0, 2'b00, 4'h6, 1);
        push(0, 32'hA000_0041, 2'b00, 4'h7, 1);
        fork
            lsu_wr(32'h8000_0100, 4'h6, 32'hDEAD_BEEF, 4'b0011);
            ifu_ar(32'h8000_0104, 4'h7, 8'd0);
        join
        drain("write");
        push(1, 32'hA000_BEEF, 2'b00, 4'h8, 1);
        lsu_ar(32'h8000_0100, 4'h8, 8'd0);
        drain("readback");

        // IFU 4-beat burst under rready backpressure holds off a waiting LSU read.
        for (int i = 0; i < 4; i++) push(0, 32'hA000_0008 + i, 2'b00, 4'h9, i == 3);
        push(1, 32'hA000_000C, 2'b00, 4'hA, 1);
        fork
            ifu_ar(32'h8000_0020, 4'h9, 8'd3);
            lsu_ar(32'h8000_0030, 4'hA, 8'd0);
            begin
                for (int i = 0; i < 10; i++) begin tick(); ifu_rready = ~ifu_rready; end
                ifu_rready = 1;
            end
        join
        drain("burst");

        // Reset in the middle of an 8-beat burst.
        for (int i = 0; i < 8; i++) push(0, 32'hA000_0010 + i, 2'b00, 4'hB, i == 7);
        ifu_ar(32'h8000_0040, 4'hB, 8'd7);
        for (int n = 0; n < 50 && exp_q.size() > 6; n++) begin @(negedge clock); #1; end
        @(posedge clock); #2;
        reset = 0;
        #1;
        outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready};
        checks++;
        if (outs != 12'h000 || exp_q.size() != 6) begin
            errors++;
            $display("FAIL midburst_reset: outputs=%h pending=%0d, required 000 and 6", outs, exp_q.size());
        end
        exp_q.delete();
        repeat (3) tick();
        reset = 1;
        tick();
        push(1, 32'hA000_0004, 2'b00, 4'hC, 1);
        lsu_ar(32'h8000_0010, 4'hC, 8'd0);
        drain("after_reset");

        // SLVERR passes through untouched with the original id.
        push(1, 32'h0000_0413, 2'b10, 4'h5, 1);
        lsu_ar(32'h0000_0000, 4'h5, 8'd0);
        drain("slverr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
